psram_acq_sequencer: RTL and testbench
======================================

Name: psram_acq_sequencer

Overview:
Control stage directly upstream of the PSRAM driver. Runs single-shot capture: it arms, waits for sample-FIFO data, and issues burst write commands at sequential PSRAM addresses until DEPTH words are stored. On request it then reads the same region back word-by-word and presents the data through a valid/ready port to the readout path (UART/host).

Parameters:
DEPTH, 4096, number of 16-bit words per capture (>=2)
BASE_ADDR, 23'h000000, first PSRAM byte address of the capture buffer
WORD_STEP, 2, byte-address increment per 16-bit word

Ports:
mem_clk  in  1  system clock, same 84MHz clock that feeds the PSRAM driver; all logic on posedge
rst  in  1  synchronous, active-high reset
qpi_on  in  1  PSRAM initialisation done
arm  in  1  one-cycle pulse: start capture
abort  in  1  one-cycle pulse: end capture early
readback_req  in  1  one-cycle pulse: start readback
fifo_empty  in  1  sample FIFO empty
write_ended  in  1  driver pulse: one word shifted out
endcommand  in  1  driver pulse: command finished
psram_data  in  16  driver read data, valid when endcommand follows a read
address  out  23  PSRAM byte address of the current command
read_write  out  2  1 = write, 2 = read, 0 = none
quad_start  out  1  one-cycle command request
burst_mode  out  1  high in all write states
stop_acquisition  out  1  tells the driver to end the current burst
rd_data  out  16  readback word
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
words_written  out  $clog2(DEPTH+1)  committed word count, saturates at DEPTH
capture_done  out  1  capture region full or aborted
overrun  out  1  sticky: write_ended seen while words_written == DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE; address = BASE_ADDR.
  - read_write, quad_start, burst_mode, stop_acquisition, rd_valid, capture_done, overrun, busy = 0.
  - rd_data = 0; words_written = 0.
- States: IDLE, WAIT_DATA, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE:
  - arm with qpi_on=1: clear words_written, capture_done and overrun; set address = BASE_ADDR; go to WAIT_DATA.
  - arm with qpi_on=0: ignored.
  - readback_req with capture_done=1: set address = BASE_ADDR; clear the read count; go to RD_ISSUE. Otherwise ignored.
- WAIT_DATA:
  - fifo_empty=0 and stop_acquisition=0: go to WR_ISSUE.
  - stop_acquisition=1: go to IDLE and set capture_done.
- WR_ISSUE:
  - read_write=1, burst_mode=1, quad_start=1 for exactly one cycle.
  - address = BASE_ADDR + WORD_STEP*words_written. It is frozen until the next WR_ISSUE.
  - Next state: WR_WAIT.
- WR_WAIT:
  - Each write_ended pulse increments words_written, saturating at DEPTH. A pulse at saturation sets overrun.
  - On endcommand: go to WAIT_DATA. read_write returns to 0.
- stop_acquisition is registered:
  - Set when words_written >= DEPTH-1 after the update. This gives one word of margin, because the driver decides burst continuation two half-cycles after write_ended.
  - Also set on abort.
  - Held until the next arm or rst.
- RD_ISSUE:
  - read_write=2, quad_start=1 for one cycle; burst_mode=0.
  - address = BASE_ADDR + WORD_STEP*read_count.
  - Next state: RD_WAIT.
- RD_WAIT:
  - On endcommand: capture psram_data into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD:
  - rd_data stays stable while rd_valid=1 and rd_ready=0.
  - On rd_valid & rd_ready: clear rd_valid and increment read_count.
  - If read_count reaches words_written: go to IDLE. Otherwise go to RD_ISSUE.
- Readback latency: word N+1 command issues the cycle after the word N handshake.
- Simultaneous events:
  - abort has priority over arm.
  - arm or readback_req while busy: ignored.
  - endcommand outside WR_WAIT/RD_WAIT: ignored.
- Reset mid-command: state goes to IDLE on the next edge with all outputs at reset values. The in-flight PSRAM command completes by itself; its endcommand is ignored.
- Address arithmetic is 23-bit unsigned, no wrap. BASE_ADDR + WORD_STEP*DEPTH must fit in 23 bits; the bench checks this as an elaboration assertion.

Test Plan:
- Reset, qpi_on=1, DEPTH=8, arm, FIFO never empty, driver model bursting 4 words per command → two write commands at addresses 0x000000 and 0x000008. stop_acquisition rises once words_written=7. Final words_written=8, capture_done=1, overrun=0.
- Same setup, but the driver model emits a 9th write_ended after stop → words_written stays 8, overrun=1.
- arm while qpi_on=0 → busy stays 0, no quad_start pulse.
- After capture, readback_req with rd_ready held low 5 cycles per word → 8 read commands at 0x0, 0x2 … 0xE. rd_data equals the model data and stays stable while stalled. Returns to IDLE after the 8th handshake.
- Abort after 3 words, then readback → capture_done=1, words_written=3, exactly 3 words read back.
- rst asserted in WR_WAIT → next cycle: all outputs at reset values, state IDLE. A late endcommand causes no quad_start.

Source files
------------

// File: rtl/psram_acq_sequencer_if.sv
// PSRAM driver command/response bus plus the valid/ready readout port of the
// acquisition sequencer.
interface psram_acq_sequencer_if;
   logic [22:0] address;
   logic [1:0]  read_write;
   logic        quad_start;
   logic        burst_mode;
   logic        stop_acquisition;
   logic        write_ended;
   logic        endcommand;
   logic [15:0] psram_data;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;

   modport master (
      output address, read_write, quad_start, burst_mode, stop_acquisition,
      output rd_data, rd_valid,
      input  write_ended, endcommand, psram_data, rd_ready
   );

   modport slave (
      input  address, read_write, quad_start, burst_mode, stop_acquisition,
      input  rd_data, rd_valid,
      output write_ended, endcommand, psram_data, rd_ready
   );
endinterface

// File: rtl/psram_acq_sequencer.sv
// Single-shot capture sequencer: burst-writes FIFO samples to a PSRAM region,
// then reads the region back word by word through a valid/ready port.
module psram_acq_sequencer #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [22:0] BASE_ADDR = 23'h000000,
   parameter int unsigned WORD_STEP = 2,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic                 mem_clk,
   input  logic                 rst,
   input  logic                 qpi_on,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 readback_req,
   input  logic                 fifo_empty,
   psram_acq_sequencer_if.master bus,
   output logic [CW-1:0]        words_written,
   output logic                 capture_done,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE, WAIT_DATA, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_HOLD
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] read_count;
   logic [CW-1:0] ww_inc, rc_inc;
   logic [22:0]   wr_addr, rd_addr_next;
   logic          arm_ok, rb_ok, capturing, handshake;

   assign arm_ok       = arm && !abort && qpi_on;
   assign rb_ok        = readback_req && capture_done;
   assign capturing    = (state == WAIT_DATA) || (state == WR_ISSUE) || (state == WR_WAIT);
   assign handshake    = bus.rd_valid && bus.rd_ready;
   assign ww_inc       = (words_written == CW'(DEPTH)) ? words_written : words_written + CW'(1);
   assign rc_inc       = read_count + CW'(1);
   assign wr_addr      = BASE_ADDR + 23'(WORD_STEP) * 23'(words_written);
   assign rd_addr_next = BASE_ADDR + 23'(WORD_STEP) * 23'(rc_inc);
   assign busy         = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no branch can infer a latch.
   always_comb begin
      state_next     = state;
      bus.quad_start = 1'b0;
      bus.read_write = 2'd0;
      bus.burst_mode = 1'b0;
      case (state)
         IDLE: begin
            if (arm_ok)     state_next = WAIT_DATA;
            else if (rb_ok) state_next = RD_ISSUE;
         end
         WAIT_DATA: begin
            if (bus.stop_acquisition) state_next = IDLE;
            else if (!fifo_empty)     state_next = WR_ISSUE;
         end
         WR_ISSUE: begin
            bus.quad_start = 1'b1;
            bus.read_write = 2'd1;
            bus.burst_mode = 1'b1;
            state_next     = WR_WAIT;
         end
         WR_WAIT: begin
            bus.read_write = 2'd1;
            bus.burst_mode = 1'b1;
            if (bus.endcommand) state_next = WAIT_DATA;
         end
         RD_ISSUE: begin
            bus.quad_start = 1'b1;
            bus.read_write = 2'd2;
            state_next     = RD_WAIT;
         end
         RD_WAIT: begin
            bus.read_write = 2'd2;
            if (bus.endcommand) state_next = RD_HOLD;
         end
         RD_HOLD: begin
            if (handshake) state_next = (rc_inc >= words_written) ? IDLE : RD_ISSUE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: all registered state uses non-blocking assignment so every branch sees pre-edge values.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state                <= IDLE;
         bus.address          <= BASE_ADDR;
         bus.stop_acquisition <= 1'b0;
         bus.rd_data          <= 16'h0000;
         bus.rd_valid         <= 1'b0;
         words_written        <= '0;
         read_count           <= '0;
         capture_done         <= 1'b0;
         overrun              <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (arm_ok) begin
                  words_written        <= '0;
                  capture_done         <= 1'b0;
                  overrun              <= 1'b0;
                  bus.stop_acquisition <= 1'b0;
                  bus.address          <= BASE_ADDR;
               end else if (rb_ok) begin
                  bus.address <= BASE_ADDR;
                  read_count  <= '0;
               end
            end
            WAIT_DATA: begin
               if (bus.stop_acquisition) capture_done <= 1'b1;
               else if (!fifo_empty)     bus.address  <= wr_addr;
            end
            WR_WAIT: begin
               if (bus.write_ended) begin
                  if (words_written == CW'(DEPTH)) overrun <= 1'b1;
                  words_written <= ww_inc;
                  // One word of margin: the driver commits to the next word before it sees stop.
                  if (ww_inc >= CW'(DEPTH - 1)) bus.stop_acquisition <= 1'b1;
               end
            end
            RD_WAIT: begin
               if (bus.endcommand) begin
                  bus.rd_data  <= bus.psram_data;
                  bus.rd_valid <= 1'b1;
               end
            end
            RD_HOLD: begin
               if (handshake) begin
                  bus.rd_valid <= 1'b0;
                  read_count   <= rc_inc;
                  bus.address  <= rd_addr_next;
               end
            end
            default: ;
         endcase
         if (abort && capturing) bus.stop_acquisition <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psram_acq_sequencer.sv
// Directed bench for psram_acq_sequencer with a behavioural PSRAM driver and
// command/data scoreboards.
module tb_psram_acq_sequencer;
   localparam int unsigned DEPTH     = 8;
   localparam logic [22:0] BASE_ADDR = 23'h000000;
   localparam int unsigned WORD_STEP = 2;
   localparam int unsigned CW        = $clog2(DEPTH + 1);

   logic          mem_clk = 1'b0;
   logic          rst = 1'b1;
   logic          qpi_on = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          readback_req = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [CW-1:0] words_written;
   logic          capture_done, overrun, busy;

   psram_acq_sequencer_if bus ();

   psram_acq_sequencer #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .WORD_STEP(WORD_STEP)
   ) dut (
      .mem_clk(mem_clk), .rst(rst), .qpi_on(qpi_on), .arm(arm), .abort(abort),
      .readback_req(readback_req), .fifo_empty(fifo_empty), .bus(bus),
      .words_written(words_written), .capture_done(capture_done),
      .overrun(overrun), .busy(busy)
   );

   always #6 mem_clk = ~mem_clk;

   initial begin
      if (longint'(BASE_ADDR) + longint'(WORD_STEP) * longint'(DEPTH) >= (64'd1 << 23))
         $fatal(1, "capture region does not fit in 23-bit address space");
   end

   int total = 0;
   int bad   = 0;

   // Driver-model settings (written by the stimulus, read by the driver model).
   int   burst_words = 4;
   logic ignore_stop = 1'b0;

   // Observed commands {read_write, address} and words_written at each stop rise.
   logic [24:0] obs_cmd_q[$];
   int          stop_ww_q[$];
   // Expected commands and readback data.
   logic [24:0] exp_cmd_q[$];
   logic [15:0] exp_data_q[$];
   int          obs_idx  = 0;
   int          stop_idx = 0;

   function automatic logic [15:0] model_data(input logic [22:0] a);
      return {a[7:0], ~a[7:0]} ^ 16'h5A00;
   endfunction

   // PSRAM driver model: reads answer after two cycles; writes burst up to
   // burst_words words and decide continuation from stop as each word starts.
   initial begin
      logic [22:0] a;
      logic [1:0]  rw;
      logic        go;
      bus.write_ended = 1'b0;
      bus.endcommand  = 1'b0;
      bus.psram_data  = 16'h0000;
      forever begin
         @(negedge mem_clk);
         if (bus.quad_start) begin
            a  = bus.address;
            rw = bus.read_write;
            obs_cmd_q.push_back({rw, a});
            if (rw == 2'd2) begin
               repeat (2) @(negedge mem_clk);
               bus.psram_data = model_data(a);
               bus.endcommand = 1'b1;
               @(negedge mem_clk);
               bus.endcommand = 1'b0;
            end else begin
               for (int k = 0; k < burst_words; k++) begin
                  @(negedge mem_clk);
                  bus.write_ended = 1'b1;
                  go = ignore_stop || !bus.stop_acquisition;
                  @(negedge mem_clk);
                  bus.write_ended = 1'b0;
                  if (!go) break;
               end
               @(negedge mem_clk);
               bus.endcommand = 1'b1;
               @(negedge mem_clk);
               bus.endcommand = 1'b0;
            end
         end
      end
   end

   initial begin
      logic prev_stop;
      prev_stop = 1'b0;
      forever begin
         @(negedge mem_clk);
         if (bus.stop_acquisition && !prev_stop) stop_ww_q.push_back(int'(words_written));
         prev_stop = bus.stop_acquisition;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] rw, input logic [22:0] a);
      exp_cmd_q.push_back({rw, a});
   endtask

   task automatic compare_cmds(input string tag);
      logic [24:0] e;
      while (exp_cmd_q.size() > 0) begin
         e = exp_cmd_q.pop_front();
         if (obs_idx < obs_cmd_q.size()) begin
            check({tag, "_cmd"}, obs_cmd_q[obs_idx], e);
            obs_idx++;
         end else begin
            check({tag, "_cmd_missing"}, obs_cmd_q.size(), obs_idx + 1);
         end
      end
      check({tag, "_cmd_count"}, obs_cmd_q.size(), obs_idx);
      obs_idx = obs_cmd_q.size();
   endtask

   task automatic check_stop_rise(input string tag, input int exp_ww);
      check({tag, "_stop_rises"}, stop_ww_q.size(), stop_idx + 1);
      if (stop_ww_q.size() > stop_idx) check({tag, "_stop_ww"}, stop_ww_q[stop_idx], exp_ww);
      stop_idx = stop_ww_q.size();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge mem_clk);
      arm = 1'b0;
   endtask

   task automatic wait_capture(input string tag, input int limit);
      int cyc = 0;
      while (!capture_done && cyc < limit) begin
         @(negedge mem_clk);
         cyc++;
      end
      check({tag, "_capture_done"}, capture_done, 1'b1);
   endtask

   task automatic wait_ww(input string tag, input int val, input int limit);
      int cyc = 0;
      while (int'(words_written) != val && cyc < limit) begin
         @(negedge mem_clk);
         cyc++;
      end
      check({tag, "_reach_ww"}, words_written, val);
   endtask

   task automatic do_readback(input string tag, input int n, input int stall);
      int          cyc;
      logic [15:0] e;
      for (int i = 0; i < n; i++) begin
         expect_cmd(2'd2, BASE_ADDR + 23'(WORD_STEP * i));
         exp_data_q.push_back(model_data(BASE_ADDR + 23'(WORD_STEP * i)));
      end
      readback_req = 1'b1;
      @(negedge mem_clk);
      readback_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         cyc = 0;
         while (!bus.rd_valid && cyc < 50) begin
            @(negedge mem_clk);
            cyc++;
         end
         check({tag, "_rd_valid"}, bus.rd_valid, 1'b1);
         e = exp_data_q.pop_front();
         check({tag, "_rd_data"}, bus.rd_data, e);
         repeat (stall) @(negedge mem_clk);
         check({tag, "_stall_valid"}, bus.rd_valid, 1'b1);
         check({tag, "_stall_data"}, bus.rd_data, e);
         bus.rd_ready = 1'b1;
         @(negedge mem_clk);
         bus.rd_ready = 1'b0;
         check({tag, "_valid_drop"}, bus.rd_valid, 1'b0);
         if (i < n - 1) check({tag, "_next_issue"}, bus.quad_start, 1'b1);
         else           check({tag, "_idle"}, busy, 1'b0);
      end
      repeat (4) @(negedge mem_clk);
      compare_cmds(tag);
   endtask

   initial begin
      int base;
      int cyc;
      bus.rd_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge mem_clk);
      check("rst_address", bus.address, BASE_ADDR);
      check("rst_read_write", bus.read_write, 2'd0);
      check("rst_quad_start", bus.quad_start, 1'b0);
      check("rst_burst_mode", bus.burst_mode, 1'b0);
      check("rst_stop", bus.stop_acquisition, 1'b0);
      check("rst_rd_valid", bus.rd_valid, 1'b0);
      check("rst_rd_data", bus.rd_data, 16'h0000);
      check("rst_words", words_written, 0);
      check("rst_capture_done", capture_done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      @(negedge mem_clk);

      // Readback request without a finished capture is ignored
      readback_req = 1'b1;
      @(negedge mem_clk);
      readback_req = 1'b0;
      repeat (3) @(negedge mem_clk);
      check("norb_busy", busy, 1'b0);
      check("norb_cmds", obs_cmd_q.size(), 0);

      // Arm while PSRAM not initialised is ignored
      fifo_empty = 1'b0;
      pulse_arm();
      repeat (5) @(negedge mem_clk);
      check("noqpi_busy", busy, 1'b0);
      check("noqpi_cmds", obs_cmd_q.size(), 0);

      // Full capture, 4-word bursts
      qpi_on      = 1'b1;
      burst_words = 4;
      ignore_stop = 1'b0;
      expect_cmd(2'd1, 23'h000000);
      expect_cmd(2'd1, 23'h000008);
      pulse_arm();
      wait_capture("cap", 400);
      check("cap_words", words_written, DEPTH);
      check("cap_overrun", overrun, 1'b0);
      check("cap_busy", busy, 1'b0);
      check("cap_stop_held", bus.stop_acquisition, 1'b1);
      check_stop_rise("cap", DEPTH - 1);
      compare_cmds("cap");

      // Readback of the full region with 5-cycle consumer stalls
      do_readback("rb", DEPTH, 5);

      // Driver ignores stop: ninth write_ended must saturate and flag overrun
      burst_words = 3;
      ignore_stop = 1'b1;
      expect_cmd(2'd1, 23'h000000);
      expect_cmd(2'd1, 23'h000006);
      expect_cmd(2'd1, 23'h00000C);
      pulse_arm();
      check("ovr_cleared", capture_done, 1'b0);
      wait_capture("ovr", 600);
      check("ovr_words", words_written, DEPTH);
      check("ovr_overrun", overrun, 1'b1);
      check_stop_rise("ovr", DEPTH - 1);
      compare_cmds("ovr");

      // Abort after three words, then read back only those
      ignore_stop = 1'b0;
      burst_words = 3;
      fifo_empty  = 1'b0;
      expect_cmd(2'd1, 23'h000000);
      base = obs_cmd_q.size();
      pulse_arm();
      check("abt_overrun_cleared", overrun, 1'b0);
      cyc = 0;
      while (obs_cmd_q.size() == base && cyc < 50) begin
         @(negedge mem_clk);
         cyc++;
      end
      fifo_empty = 1'b1;
      wait_ww("abt", 3, 100);
      repeat (4) @(negedge mem_clk);
      check("abt_busy_waiting", busy, 1'b1);
      check("abt_not_done", capture_done, 1'b0);
      abort = 1'b1;
      @(negedge mem_clk);
      abort = 1'b0;
      wait_capture("abt", 20);
      check("abt_words", words_written, 3);
      check("abt_busy", busy, 1'b0);
      compare_cmds("abt");
      do_readback("abt_rb", 3, 1);

      // Synchronous reset in the middle of the second write burst
      burst_words = 4;
      fifo_empty  = 1'b0;
      expect_cmd(2'd1, 23'h000000);
      expect_cmd(2'd1, 23'h000008);
      pulse_arm();
      wait_ww("mid", 6, 200);
      check("mid_rw_before", bus.read_write, 2'd1);
      rst = 1'b1;
      @(negedge mem_clk);
      check("mid_address", bus.address, BASE_ADDR);
      check("mid_read_write", bus.read_write, 2'd0);
      check("mid_quad_start", bus.quad_start, 1'b0);
      check("mid_burst_mode", bus.burst_mode, 1'b0);
      check("mid_stop", bus.stop_acquisition, 1'b0);
      check("mid_rd_valid", bus.rd_valid, 1'b0);
      check("mid_rd_data", bus.rd_data, 16'h0000);
      check("mid_words", words_written, 0);
      check("mid_capture_done", capture_done, 1'b0);
      check("mid_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (15) @(negedge mem_clk);
      check("mid_late_busy", busy, 1'b0);
      check("mid_late_words", words_written, 0);
      compare_cmds("mid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
